// File: rtl/wg_resource_allocator_pkg.sv
// wg_resource_allocator_pkg
// Shared widths, reset defaults, FSM state encoding and the per-CU resource
// entry type for the workgroup resource allocator.
package wg_resource_allocator_pkg;

    localparam int WG_ID_WIDTH       = 8;
    localparam int CU_ID_WIDTH       = 2;
    localparam int NUMBER_CU         = 4;
    localparam int VGPR_ID_WIDTH     = 8;
    localparam int NUMBER_VGPR_SLOTS = 256;
    localparam int SGPR_ID_WIDTH     = 8;
    localparam int NUMBER_SGPR_SLOTS = 256;
    localparam int LDS_ID_WIDTH      = 7;
    localparam int NUMBER_LDS_SLOTS  = 128;
    localparam int GDS_ID_WIDTH      = 7;
    localparam int GDS_SIZE          = 128;
    localparam int WG_SLOT_ID_WIDTH  = 6;
    localparam int NUMBER_WF_SLOTS   = 40;

    // state     | meaning
    // ST_IDLE   | waiting for start_alloc, request latch open
    // ST_SEARCH | parallel fit compare, winner registered at end of cycle
    // ST_RESULT | valid or rejected held until alloc_ack
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RESULT = 2'd2
    } alloc_state_t;

    // Largest free block per resource plus free wavefront slots for one CU.
    typedef struct packed {
        logic [WG_SLOT_ID_WIDTH-1:0] wf_free;
        logic [VGPR_ID_WIDTH-1:0]    vgpr_strt;
        logic [VGPR_ID_WIDTH:0]      vgpr_size;
        logic [SGPR_ID_WIDTH-1:0]    sgpr_strt;
        logic [SGPR_ID_WIDTH:0]      sgpr_size;
        logic [LDS_ID_WIDTH-1:0]     lds_strt;
        logic [LDS_ID_WIDTH:0]       lds_size;
        logic [GDS_ID_WIDTH-1:0]     gds_strt;
        logic [GDS_ID_WIDTH:0]       gds_size;
    } cu_entry_t;

    // What a workgroup needs; this is what gets matched against each entry.
    typedef struct packed {
        logic [WG_SLOT_ID_WIDTH:0] num_wf;
        logic [VGPR_ID_WIDTH:0]    vgpr_size;
        logic [SGPR_ID_WIDTH:0]    sgpr_size;
        logic [LDS_ID_WIDTH:0]     lds_size;
        logic [GDS_ID_WIDTH:0]     gds_size;
    } fit_req_t;

    // Entry of an idle CU: every slot free, every block spans the whole pool.
    function automatic cu_entry_t empty_cu_entry();
        cu_entry_t e;
        e.wf_free   = WG_SLOT_ID_WIDTH'(NUMBER_WF_SLOTS);
        e.vgpr_strt = '0;
        e.vgpr_size = (VGPR_ID_WIDTH+1)'(NUMBER_VGPR_SLOTS);
        e.sgpr_strt = '0;
        e.sgpr_size = (SGPR_ID_WIDTH+1)'(NUMBER_SGPR_SLOTS);
        e.lds_strt  = '0;
        e.lds_size  = (LDS_ID_WIDTH+1)'(NUMBER_LDS_SLOTS);
        e.gds_strt  = '0;
        e.gds_size  = (GDS_ID_WIDTH+1)'(GDS_SIZE);
        return e;
    endfunction

endpackage

// File: rtl/wg_resource_allocator_if.sv
// wg_resource_allocator_if
// Request, result and cam-update signals between the dispatcher side
// (master) and the allocator (slave).
interface wg_resource_allocator_if;
    import wg_resource_allocator_pkg::*;

    logic [WG_ID_WIDTH-1:0]      inflight_wg_buffer_alloc_wg_id;
    logic [WG_SLOT_ID_WIDTH:0]   inflight_wg_buffer_alloc_num_wf;
    logic [VGPR_ID_WIDTH:0]      inflight_wg_buffer_alloc_vgpr_size;
    logic [SGPR_ID_WIDTH:0]      inflight_wg_buffer_alloc_sgpr_size;
    logic [LDS_ID_WIDTH:0]       inflight_wg_buffer_alloc_lds_size;
    logic [GDS_ID_WIDTH:0]       inflight_wg_buffer_alloc_gds_size;

    logic                        dis_controller_start_alloc;
    logic                        dis_controller_alloc_ack;
    logic [NUMBER_CU-1:0]        dis_controller_cu_busy;

    logic                        grt_cam_up_valid;
    logic [CU_ID_WIDTH-1:0]      grt_cam_up_cu_id;
    logic [WG_SLOT_ID_WIDTH-1:0] grt_cam_up_wg_count;
    logic [VGPR_ID_WIDTH-1:0]    grt_cam_up_vgpr_strt;
    logic [VGPR_ID_WIDTH:0]      grt_cam_up_vgpr_size;
    logic [SGPR_ID_WIDTH-1:0]    grt_cam_up_sgpr_strt;
    logic [SGPR_ID_WIDTH:0]      grt_cam_up_sgpr_size;
    logic [LDS_ID_WIDTH-1:0]     grt_cam_up_lds_strt;
    logic [LDS_ID_WIDTH:0]       grt_cam_up_lds_size;
    logic [GDS_ID_WIDTH-1:0]     grt_cam_up_gds_strt;
    logic [GDS_ID_WIDTH:0]       grt_cam_up_gds_size;

    logic                        allocator_cu_valid;
    logic                        allocator_cu_rejected;
    logic [WG_ID_WIDTH-1:0]      allocator_wg_id_out;
    logic [CU_ID_WIDTH-1:0]      allocator_cu_id_out;
    logic [VGPR_ID_WIDTH-1:0]    allocator_vgpr_start_out;
    logic [SGPR_ID_WIDTH-1:0]    allocator_sgpr_start_out;
    logic [LDS_ID_WIDTH-1:0]     allocator_lds_start_out;
    logic [GDS_ID_WIDTH-1:0]     allocator_gds_start_out;
    logic [VGPR_ID_WIDTH:0]      allocator_vgpr_size_out;
    logic [SGPR_ID_WIDTH:0]      allocator_sgpr_size_out;
    logic [LDS_ID_WIDTH:0]       allocator_lds_size_out;
    logic [GDS_ID_WIDTH:0]       allocator_gds_size_out;

    modport master (
        output inflight_wg_buffer_alloc_wg_id, inflight_wg_buffer_alloc_num_wf,
               inflight_wg_buffer_alloc_vgpr_size, inflight_wg_buffer_alloc_sgpr_size,
               inflight_wg_buffer_alloc_lds_size, inflight_wg_buffer_alloc_gds_size,
               dis_controller_start_alloc, dis_controller_alloc_ack, dis_controller_cu_busy,
               grt_cam_up_valid, grt_cam_up_cu_id, grt_cam_up_wg_count,
               grt_cam_up_vgpr_strt, grt_cam_up_vgpr_size, grt_cam_up_sgpr_strt,
               grt_cam_up_sgpr_size, grt_cam_up_lds_strt, grt_cam_up_lds_size,
               grt_cam_up_gds_strt, grt_cam_up_gds_size,
        input  allocator_cu_valid, allocator_cu_rejected, allocator_wg_id_out,
               allocator_cu_id_out, allocator_vgpr_start_out, allocator_sgpr_start_out,
               allocator_lds_start_out, allocator_gds_start_out, allocator_vgpr_size_out,
               allocator_sgpr_size_out, allocator_lds_size_out, allocator_gds_size_out
    );

    modport slave (
        input  inflight_wg_buffer_alloc_wg_id, inflight_wg_buffer_alloc_num_wf,
               inflight_wg_buffer_alloc_vgpr_size, inflight_wg_buffer_alloc_sgpr_size,
               inflight_wg_buffer_alloc_lds_size, inflight_wg_buffer_alloc_gds_size,
               dis_controller_start_alloc, dis_controller_alloc_ack, dis_controller_cu_busy,
               grt_cam_up_valid, grt_cam_up_cu_id, grt_cam_up_wg_count,
               grt_cam_up_vgpr_strt, grt_cam_up_vgpr_size, grt_cam_up_sgpr_strt,
               grt_cam_up_sgpr_size, grt_cam_up_lds_strt, grt_cam_up_lds_size,
               grt_cam_up_gds_strt, grt_cam_up_gds_size,
        output allocator_cu_valid, allocator_cu_rejected, allocator_wg_id_out,
               allocator_cu_id_out, allocator_vgpr_start_out, allocator_sgpr_start_out,
               allocator_lds_start_out, allocator_gds_start_out, allocator_vgpr_size_out,
               allocator_sgpr_size_out, allocator_lds_size_out, allocator_gds_size_out
    );

endinterface

// File: rtl/wg_resource_allocator_cu_resource_table.sv
// wg_resource_allocator_cu_resource_table
// One resource entry per CU, written only by the cam-update port, and a
// parallel fit compare of the latched request against every entry.
module wg_resource_allocator_cu_resource_table
    import wg_resource_allocator_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_up_valid,
    input  logic [CU_ID_WIDTH-1:0]    i_up_cu_id,
    input  cu_entry_t                 i_up_entry,
    input  fit_req_t                  i_req,
    input  logic [NUMBER_CU-1:0]      i_cu_busy,
    output logic [NUMBER_CU-1:0]      o_eligible,
    output logic [VGPR_ID_WIDTH-1:0]  o_vgpr_strt [NUMBER_CU],
    output logic [SGPR_ID_WIDTH-1:0]  o_sgpr_strt [NUMBER_CU],
    output logic [LDS_ID_WIDTH-1:0]   o_lds_strt  [NUMBER_CU],
    output logic [GDS_ID_WIDTH-1:0]   o_gds_strt  [NUMBER_CU]
);

    cu_entry_t r_entries [NUMBER_CU];

    // Entry storage: empty machine on reset, whole-entry overwrite on update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUMBER_CU; i++) begin
                r_entries[i] <= empty_cu_entry();
            end
        end else if (i_up_valid) begin
            r_entries[i_up_cu_id] <= i_up_entry;
        end
    end

    // Fit compare reads the registered entries, so an update landing on the
    // same edge as the search is not seen until the next search.
    always_comb begin
        o_eligible = '0;
        for (int i = 0; i < NUMBER_CU; i++) begin
            o_eligible[i] = !i_cu_busy[i]
                          && ({1'b0, r_entries[i].wf_free} >= i_req.num_wf)
                          && (r_entries[i].vgpr_size >= i_req.vgpr_size)
                          && (r_entries[i].sgpr_size >= i_req.sgpr_size)
                          && (r_entries[i].lds_size  >= i_req.lds_size)
                          && (r_entries[i].gds_size  >= i_req.gds_size);
        end
    end

    // Start fields exported so the top can forward the winner's blocks.
    always_comb begin
        for (int i = 0; i < NUMBER_CU; i++) begin
            o_vgpr_strt[i] = r_entries[i].vgpr_strt;
            o_sgpr_strt[i] = r_entries[i].sgpr_strt;
            o_lds_strt[i]  = r_entries[i].lds_strt;
            o_gds_strt[i]  = r_entries[i].gds_strt;
        end
    end

endmodule

// File: rtl/wg_resource_allocator.sv
// wg_resource_allocator
// Picks a CU for the workgroup at the head of the inflight buffer and reports
// accept/reject to the dispatcher controller.
// Optional macro ALLOCATOR_ROUND_ROBIN_EN: search begins one past the last
// granted CU instead of always at CU0.
module wg_resource_allocator
    import wg_resource_allocator_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    wg_resource_allocator_if.slave   bus
);

    alloc_state_t             r_state;
    alloc_state_t             w_next_state;
    logic [WG_ID_WIDTH-1:0]   r_wg_id;
    fit_req_t                 r_req;
    cu_entry_t                w_up_entry;
    logic [NUMBER_CU-1:0]     w_eligible;
    logic                     w_found;
    logic [CU_ID_WIDTH-1:0]   w_winner;
    logic [VGPR_ID_WIDTH-1:0] w_vgpr_strt [NUMBER_CU];
    logic [SGPR_ID_WIDTH-1:0] w_sgpr_strt [NUMBER_CU];
    logic [LDS_ID_WIDTH-1:0]  w_lds_strt  [NUMBER_CU];
    logic [GDS_ID_WIDTH-1:0]  w_gds_strt  [NUMBER_CU];
`ifdef ALLOCATOR_ROUND_ROBIN_EN
    logic [CU_ID_WIDTH-1:0]   r_rr_ptr;
`endif

    assign w_up_entry.wf_free   = bus.grt_cam_up_wg_count;
    assign w_up_entry.vgpr_strt = bus.grt_cam_up_vgpr_strt;
    assign w_up_entry.vgpr_size = bus.grt_cam_up_vgpr_size;
    assign w_up_entry.sgpr_strt = bus.grt_cam_up_sgpr_strt;
    assign w_up_entry.sgpr_size = bus.grt_cam_up_sgpr_size;
    assign w_up_entry.lds_strt  = bus.grt_cam_up_lds_strt;
    assign w_up_entry.lds_size  = bus.grt_cam_up_lds_size;
    assign w_up_entry.gds_strt  = bus.grt_cam_up_gds_strt;
    assign w_up_entry.gds_size  = bus.grt_cam_up_gds_size;

    wg_resource_allocator_cu_resource_table u_table (
        .clk         (clk),
        .rst         (rst),
        .i_up_valid  (bus.grt_cam_up_valid),
        .i_up_cu_id  (bus.grt_cam_up_cu_id),
        .i_up_entry  (w_up_entry),
        .i_req       (r_req),
        .i_cu_busy   (bus.dis_controller_cu_busy),
        .o_eligible  (w_eligible),
        .o_vgpr_strt (w_vgpr_strt),
        .o_sgpr_strt (w_sgpr_strt),
        .o_lds_strt  (w_lds_strt),
        .o_gds_strt  (w_gds_strt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state: start only honoured in IDLE, result held until ack.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (bus.dis_controller_start_alloc) w_next_state = ST_SEARCH;
            ST_SEARCH: w_next_state = ST_RESULT;
            ST_RESULT: if (bus.dis_controller_alloc_ack) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, open only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wg_id <= '0;
            r_req   <= '0;
        end else if (r_state == ST_IDLE && bus.dis_controller_start_alloc) begin
            r_wg_id         <= bus.inflight_wg_buffer_alloc_wg_id;
            r_req.num_wf    <= bus.inflight_wg_buffer_alloc_num_wf;
            r_req.vgpr_size <= bus.inflight_wg_buffer_alloc_vgpr_size;
            r_req.sgpr_size <= bus.inflight_wg_buffer_alloc_sgpr_size;
            r_req.lds_size  <= bus.inflight_wg_buffer_alloc_lds_size;
            r_req.gds_size  <= bus.inflight_wg_buffer_alloc_gds_size;
        end
    end

`ifdef ALLOCATOR_ROUND_ROBIN_EN
    // Rotating priority; offsets scanned high to low so the smallest offset
    // from the pointer wins. Index wraps naturally since NUMBER_CU is 2**CU_ID_WIDTH.
    always_comb begin
        logic [CU_ID_WIDTH-1:0] v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUMBER_CU - 1; k >= 0; k--) begin
            v_idx = r_rr_ptr + CU_ID_WIDTH'(k);
            if (w_eligible[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    // Pointer moves past the winner only on a successful grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              r_rr_ptr <= '0;
        else if (r_state == ST_SEARCH && w_found) r_rr_ptr <= w_winner + 1'b1;
    end
`else
    // Fixed priority: scan high to low so the lowest eligible index wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = NUMBER_CU - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_found  = 1'b1;
                w_winner = CU_ID_WIDTH'(i);
            end
        end
    end
`endif

    // Result registers: loaded at the end of SEARCH, cleared on ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.allocator_cu_valid       <= 1'b0;
            bus.allocator_cu_rejected    <= 1'b0;
            bus.allocator_wg_id_out      <= '0;
            bus.allocator_cu_id_out      <= '0;
            bus.allocator_vgpr_start_out <= '0;
            bus.allocator_sgpr_start_out <= '0;
            bus.allocator_lds_start_out  <= '0;
            bus.allocator_gds_start_out  <= '0;
            bus.allocator_vgpr_size_out  <= '0;
            bus.allocator_sgpr_size_out  <= '0;
            bus.allocator_lds_size_out   <= '0;
            bus.allocator_gds_size_out   <= '0;
        end else if (r_state == ST_SEARCH) begin
            bus.allocator_wg_id_out <= r_wg_id;
            if (w_found) begin
                bus.allocator_cu_valid       <= 1'b1;
                bus.allocator_cu_rejected    <= 1'b0;
                bus.allocator_cu_id_out      <= w_winner;
                bus.allocator_vgpr_start_out <= w_vgpr_strt[w_winner];
                bus.allocator_sgpr_start_out <= w_sgpr_strt[w_winner];
                bus.allocator_lds_start_out  <= w_lds_strt[w_winner];
                bus.allocator_gds_start_out  <= w_gds_strt[w_winner];
                bus.allocator_vgpr_size_out  <= r_req.vgpr_size;
                bus.allocator_sgpr_size_out  <= r_req.sgpr_size;
                bus.allocator_lds_size_out   <= r_req.lds_size;
                bus.allocator_gds_size_out   <= r_req.gds_size;
            end else begin
                bus.allocator_cu_valid       <= 1'b0;
                bus.allocator_cu_rejected    <= 1'b1;
                bus.allocator_cu_id_out      <= '0;
                bus.allocator_vgpr_start_out <= '0;
                bus.allocator_sgpr_start_out <= '0;
                bus.allocator_lds_start_out  <= '0;
                bus.allocator_gds_start_out  <= '0;
                bus.allocator_vgpr_size_out  <= '0;
                bus.allocator_sgpr_size_out  <= '0;
                bus.allocator_lds_size_out   <= '0;
                bus.allocator_gds_size_out   <= '0;
            end
        end else if (r_state == ST_RESULT && bus.dis_controller_alloc_ack) begin
            bus.allocator_cu_valid       <= 1'b0;
            bus.allocator_cu_rejected    <= 1'b0;
            bus.allocator_wg_id_out      <= '0;
            bus.allocator_cu_id_out      <= '0;
            bus.allocator_vgpr_start_out <= '0;
            bus.allocator_sgpr_start_out <= '0;
            bus.allocator_lds_start_out  <= '0;
            bus.allocator_gds_start_out  <= '0;
            bus.allocator_vgpr_size_out  <= '0;
            bus.allocator_sgpr_size_out  <= '0;
            bus.allocator_lds_size_out   <= '0;
            bus.allocator_gds_size_out   <= '0;
        end
    end

endmodule

// File: tb/tb_wg_resource_allocator.sv
// tb_wg_resource_allocator
// Directed scenarios with hand-computed expectations for the allocator.
module tb_wg_resource_allocator;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    wg_resource_allocator_if bus();

    wg_resource_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start strobe for one cycle; returns at the negedge after the IDLE->SEARCH edge.
    task automatic start_alloc(input logic [7:0] wg, input logic [6:0] nwf,
                               input logic [8:0] v, input logic [8:0] s,
                               input logic [7:0] l, input logic [7:0] g);
        bus.inflight_wg_buffer_alloc_wg_id     = wg;
        bus.inflight_wg_buffer_alloc_num_wf    = nwf;
        bus.inflight_wg_buffer_alloc_vgpr_size = v;
        bus.inflight_wg_buffer_alloc_sgpr_size = s;
        bus.inflight_wg_buffer_alloc_lds_size  = l;
        bus.inflight_wg_buffer_alloc_gds_size  = g;
        bus.dis_controller_start_alloc = 1'b1;
        @(negedge clk);
        bus.dis_controller_start_alloc = 1'b0;
    endtask

    task automatic set_cam(input logic [1:0] cu, input logic [5:0] wgc,
                           input logic [7:0] vs, input logic [8:0] vz,
                           input logic [7:0] ss, input logic [8:0] sz,
                           input logic [6:0] ls, input logic [7:0] lz,
                           input logic [6:0] gs, input logic [7:0] gz);
        bus.grt_cam_up_valid     = 1'b1;
        bus.grt_cam_up_cu_id     = cu;
        bus.grt_cam_up_wg_count  = wgc;
        bus.grt_cam_up_vgpr_strt = vs;
        bus.grt_cam_up_vgpr_size = vz;
        bus.grt_cam_up_sgpr_strt = ss;
        bus.grt_cam_up_sgpr_size = sz;
        bus.grt_cam_up_lds_strt  = ls;
        bus.grt_cam_up_lds_size  = lz;
        bus.grt_cam_up_gds_strt  = gs;
        bus.grt_cam_up_gds_size  = gz;
    endtask

    task automatic cam_up(input logic [1:0] cu, input logic [5:0] wgc,
                          input logic [7:0] vs, input logic [8:0] vz,
                          input logic [7:0] ss, input logic [8:0] sz,
                          input logic [6:0] ls, input logic [7:0] lz,
                          input logic [6:0] gs, input logic [7:0] gz);
        set_cam(cu, wgc, vs, vz, ss, sz, ls, lz, gs, gz);
        @(negedge clk);
        bus.grt_cam_up_valid = 1'b0;
    endtask

    task automatic do_ack();
        bus.dis_controller_alloc_ack = 1'b1;
        @(negedge clk);
        bus.dis_controller_alloc_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.allocator_cu_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_cu_rejected !== 1'b0) begin n_err++; $display("FAIL reset_rejected: got %b want 0", bus.allocator_cu_rejected); end
        n_cmp++; if (bus.allocator_wg_id_out !== 8'd0) begin n_err++; $display("FAIL reset_wg_id: got %0d want 0", bus.allocator_wg_id_out); end
        n_cmp++; if (bus.allocator_vgpr_size_out !== 9'd0) begin n_err++; $display("FAIL reset_vgpr_size: got %0d want 0", bus.allocator_vgpr_size_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_alloc();
        start_alloc(8'h10, 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", bus.allocator_cu_valid); end
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_cu_rejected !== 1'b0) begin n_err++; $display("FAIL basic_rejected: got %b want 0", bus.allocator_cu_rejected); end
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd0) begin n_err++; $display("FAIL basic_cu_id: got %0d want 0", bus.allocator_cu_id_out); end
        n_cmp++; if (bus.allocator_wg_id_out !== 8'h10) begin n_err++; $display("FAIL basic_wg_id: got %0h want 10", bus.allocator_wg_id_out); end
        n_cmp++; if (bus.allocator_vgpr_start_out !== 8'd0) begin n_err++; $display("FAIL basic_vgpr_start: got %0d want 0", bus.allocator_vgpr_start_out); end
        n_cmp++; if (bus.allocator_vgpr_size_out !== 9'd32) begin n_err++; $display("FAIL basic_vgpr_size: got %0d want 32", bus.allocator_vgpr_size_out); end
        n_cmp++; if (bus.allocator_sgpr_size_out !== 9'd16) begin n_err++; $display("FAIL basic_sgpr_size: got %0d want 16", bus.allocator_sgpr_size_out); end
        n_cmp++; if (bus.allocator_lds_size_out !== 8'd8) begin n_err++; $display("FAIL basic_lds_size: got %0d want 8", bus.allocator_lds_size_out); end
        n_cmp++; if (bus.allocator_gds_size_out !== 8'd8) begin n_err++; $display("FAIL basic_gds_size: got %0d want 8", bus.allocator_gds_size_out); end
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b1) begin n_err++; $display("FAIL basic_hold: got %b want 1", bus.allocator_cu_valid); end
        do_ack();
        n_cmp++; if (bus.allocator_cu_valid !== 1'b0) begin n_err++; $display("FAIL basic_after_ack: got %b want 0", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_vgpr_size_out !== 9'd0) begin n_err++; $display("FAIL basic_size_after_ack: got %0d want 0", bus.allocator_vgpr_size_out); end
    endtask

    task automatic test_busy_skip();
        bus.dis_controller_cu_busy = 4'b0001;
        start_alloc(8'h11, 7'd2, 9'd256, 9'd16, 8'd8, 8'd8);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b1) begin n_err++; $display("FAIL busy_valid: got %b want 1", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd1) begin n_err++; $display("FAIL busy_cu_id: got %0d want 1", bus.allocator_cu_id_out); end
        n_cmp++; if (bus.allocator_wg_id_out !== 8'h11) begin n_err++; $display("FAIL busy_wg_id: got %0h want 11", bus.allocator_wg_id_out); end
        n_cmp++; if (bus.allocator_vgpr_size_out !== 9'd256) begin n_err++; $display("FAIL busy_vgpr_size: got %0d want 256", bus.allocator_vgpr_size_out); end
        // start while holding a result must be ignored
        start_alloc(8'h99, 7'd1, 9'd1, 9'd1, 8'd1, 8'd1);
        n_cmp++; if (bus.allocator_wg_id_out !== 8'h11) begin n_err++; $display("FAIL busy_start_ignored: got %0h want 11", bus.allocator_wg_id_out); end
        do_ack();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b0) begin n_err++; $display("FAIL busy_no_phantom: got %b want 0", bus.allocator_cu_valid); end
        bus.dis_controller_cu_busy = 4'b0000;
    endtask

    task automatic test_cam_fit();
        cam_up(2'd0, 6'd30, 8'd0, 9'd0,   8'd0, 9'd16, 7'd0, 8'd8, 7'd0, 8'd8);
        cam_up(2'd1, 6'd30, 8'd0, 9'd0,   8'd0, 9'd16, 7'd0, 8'd8, 7'd0, 8'd8);
        cam_up(2'd2, 6'd30, 8'd0, 9'd0,   8'd0, 9'd16, 7'd0, 8'd8, 7'd0, 8'd8);
        cam_up(2'd3, 6'd30, 8'd0, 9'd224, 8'd7, 9'd16, 7'd3, 8'd8, 7'd5, 8'd8);
        start_alloc(8'h12, 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b1) begin n_err++; $display("FAIL cam_valid: got %b want 1", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd3) begin n_err++; $display("FAIL cam_cu_id: got %0d want 3", bus.allocator_cu_id_out); end
        n_cmp++; if (bus.allocator_vgpr_start_out !== 8'd0) begin n_err++; $display("FAIL cam_vgpr_start: got %0d want 0", bus.allocator_vgpr_start_out); end
        n_cmp++; if (bus.allocator_sgpr_start_out !== 8'd7) begin n_err++; $display("FAIL cam_sgpr_start: got %0d want 7", bus.allocator_sgpr_start_out); end
        n_cmp++; if (bus.allocator_lds_start_out !== 7'd3) begin n_err++; $display("FAIL cam_lds_start: got %0d want 3", bus.allocator_lds_start_out); end
        n_cmp++; if (bus.allocator_gds_start_out !== 7'd5) begin n_err++; $display("FAIL cam_gds_start: got %0d want 5", bus.allocator_gds_start_out); end
        do_ack();
    endtask

    task automatic test_reject();
        cam_up(2'd3, 6'd20, 8'd0, 9'd0, 8'd0, 9'd16, 7'd0, 8'd8, 7'd0, 8'd8);
        start_alloc(8'h13, 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_rejected !== 1'b1) begin n_err++; $display("FAIL rej_rejected: got %b want 1", bus.allocator_cu_rejected); end
        n_cmp++; if (bus.allocator_cu_valid !== 1'b0) begin n_err++; $display("FAIL rej_valid: got %b want 0", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_wg_id_out !== 8'h13) begin n_err++; $display("FAIL rej_wg_id: got %0h want 13", bus.allocator_wg_id_out); end
        n_cmp++; if (bus.allocator_vgpr_size_out !== 9'd0) begin n_err++; $display("FAIL rej_vgpr_size: got %0d want 0", bus.allocator_vgpr_size_out); end
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.allocator_cu_rejected !== 1'b1) begin n_err++; $display("FAIL rej_hold: got %b want 1", bus.allocator_cu_rejected); end
        do_ack();
        n_cmp++; if (bus.allocator_cu_rejected !== 1'b0) begin n_err++; $display("FAIL rej_after_ack: got %b want 0", bus.allocator_cu_rejected); end
    endtask

    task automatic test_wf_limit();
        cam_up(2'd0, 6'd1,  8'd0, 9'd256, 8'd0, 9'd256, 7'd0, 8'd128, 7'd0, 8'd128);
        cam_up(2'd1, 6'd40, 8'd0, 9'd256, 8'd0, 9'd256, 7'd0, 8'd128, 7'd0, 8'd128);
        start_alloc(8'h14, 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd1) begin n_err++; $display("FAIL wf_skip_cu_id: got %0d want 1", bus.allocator_cu_id_out); end
        do_ack();
        start_alloc(8'h15, 7'd1, 9'd32, 9'd16, 8'd8, 8'd8);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b1) begin n_err++; $display("FAIL wf_equal_valid: got %b want 1", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd0) begin n_err++; $display("FAIL wf_equal_cu_id: got %0d want 0", bus.allocator_cu_id_out); end
        do_ack();
        bus.dis_controller_cu_busy = 4'b1111;
        start_alloc(8'h16, 7'd1, 9'd0, 9'd0, 8'd0, 8'd0);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_rejected !== 1'b1) begin n_err++; $display("FAIL allbusy_rejected: got %b want 1", bus.allocator_cu_rejected); end
        do_ack();
        bus.dis_controller_cu_busy = 4'b0000;
    endtask

    task automatic test_zero_size();
        // CU2 has vgpr size 0; a zero request must still fit it
        bus.dis_controller_cu_busy = 4'b1011;
        start_alloc(8'h17, 7'd0, 9'd0, 9'd0, 8'd0, 8'd0);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %b want 1", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd2) begin n_err++; $display("FAIL zero_cu_id: got %0d want 2", bus.allocator_cu_id_out); end
        do_ack();
        bus.dis_controller_cu_busy = 4'b0000;
    endtask

    task automatic test_no_bypass();
        cam_up(2'd0, 6'd40, 8'd0, 9'd256, 8'd0, 9'd256, 7'd0, 8'd128, 7'd0, 8'd128);
        start_alloc(8'h18, 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
        // in SEARCH now: shrink CU0 on the same edge the search completes
        set_cam(2'd0, 6'd40, 8'd0, 9'd0, 8'd0, 9'd256, 7'd0, 8'd128, 7'd0, 8'd128);
        @(negedge clk);
        bus.grt_cam_up_valid = 1'b0;
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd0) begin n_err++; $display("FAIL nobypass_cu_id: got %0d want 0", bus.allocator_cu_id_out); end
        do_ack();
        start_alloc(8'h19, 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd1) begin n_err++; $display("FAIL update_applied_cu_id: got %0d want 1", bus.allocator_cu_id_out); end
        do_ack();
    endtask

    task automatic test_reset_in_result();
        start_alloc(8'h1a, 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b1) begin n_err++; $display("FAIL rstres_pre_valid: got %b want 1", bus.allocator_cu_valid); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.allocator_cu_valid !== 1'b0) begin n_err++; $display("FAIL rstres_valid: got %b want 0", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd0) begin n_err++; $display("FAIL rstres_cu_id: got %0d want 0", bus.allocator_cu_id_out); end
        n_cmp++; if (bus.allocator_wg_id_out !== 8'd0) begin n_err++; $display("FAIL rstres_wg_id: got %0d want 0", bus.allocator_wg_id_out); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_alloc(8'h1b, 7'd2, 9'd256, 9'd16, 8'd8, 8'd8);
        @(negedge clk);
        n_cmp++; if (bus.allocator_cu_valid !== 1'b1) begin n_err++; $display("FAIL rstres_next_valid: got %b want 1", bus.allocator_cu_valid); end
        n_cmp++; if (bus.allocator_cu_id_out !== 2'd0) begin n_err++; $display("FAIL rstres_next_cu_id: got %0d want 0", bus.allocator_cu_id_out); end
        n_cmp++; if (bus.allocator_wg_id_out !== 8'h1b) begin n_err++; $display("FAIL rstres_next_wg_id: got %0h want 1b", bus.allocator_wg_id_out); end
        do_ack();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.inflight_wg_buffer_alloc_wg_id     = '0;
        bus.inflight_wg_buffer_alloc_num_wf    = '0;
        bus.inflight_wg_buffer_alloc_vgpr_size = '0;
        bus.inflight_wg_buffer_alloc_sgpr_size = '0;
        bus.inflight_wg_buffer_alloc_lds_size  = '0;
        bus.inflight_wg_buffer_alloc_gds_size  = '0;
        bus.dis_controller_start_alloc = 1'b0;
        bus.dis_controller_alloc_ack   = 1'b0;
        bus.dis_controller_cu_busy     = '0;
        set_cam(2'd0, 6'd0, 8'd0, 9'd0, 8'd0, 9'd0, 7'd0, 8'd0, 7'd0, 8'd0);
        bus.grt_cam_up_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_alloc();
        test_busy_skip();
        test_cam_fit();
        test_reject();
        test_wf_limit();
        test_zero_size();
        test_no_bypass();
        test_reset_in_result();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Never both valid and rejected.
    always @(negedge clk) begin
        if (rst && bus.allocator_cu_valid && bus.allocator_cu_rejected) begin
            n_cmp++;
            n_err++;
            $display("FAIL exclusive_flags: got valid=1 rejected=1 want not both");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
